// File: rtl/spi_master_comm_if.sv
// Host and SPI pin bundle for spi_master_comm.
interface spi_master_comm_if;
  logic       SCLK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic       start;
  logic [4:0] len;
  logic       abort;
  logic [7:0] DATA_in;
  logic       byte_load;
  logic [7:0] DATA_out;
  logic       EoB;
  logic       busy;
  logic       done;
  logic       aborted;

  // Seen from the SPI master block
  modport master (
    input  MISO, start, len, abort, DATA_in,
    output SCLK, SS, MOSI, byte_load, DATA_out, EoB, busy, done, aborted
  );

  // Seen from the host / slave side driving the master
  modport slave (
    output MISO, start, len, abort, DATA_in,
    input  SCLK, SS, MOSI, byte_load, DATA_out, EoB, busy, done, aborted
  );
endinterface

// File: rtl/spi_master_comm.sv
// SPI master, CPOL=0 / CPHA=1, LSB first, multi-byte frames with SS guard time.
module spi_master_comm #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SS_GUARD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_master_comm_if.master     bus
);

  localparam int unsigned CW = 8;  // guard / divider counter width
  localparam int unsigned BW = 6;  // byte counter width (holds 32)
  localparam int unsigned EW = 5;  // SCLK edge counter width (0..16)
  localparam int unsigned DW = 8;  // data width

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, TRANS, NEXT, HOLD} state_t;

  state_t        state_q, state_d;
  logic          sclk_q, sclk_d;
  logic          ss_q, ss_d;
  logic          mosi_q, mosi_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          eob_q, eob_d;
  logic          byte_load_q, byte_load_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          busy_q, busy_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] guard_cnt_q, guard_cnt_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;

  // Next-state, shift-register and output computation
  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    mosi_d      = mosi_q;
    data_out_d  = data_out_q;
    eob_d       = 1'b0;
    byte_load_d = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    guard_cnt_d = guard_cnt_q;
    div_cnt_d   = div_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;

    if (state_q != IDLE && bus.abort) begin
      // Abort drops the partial byte silently and releases the bus at once
      state_d   = IDLE;
      sclk_d    = 1'b0;
      ss_d      = 1'b1;
      mosi_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_d = 1'b0;
          ss_d   = 1'b1;
          mosi_d = 1'b0;
          if (bus.start && !bus.abort) begin
            state_d     = SETUP;
            ss_d        = 1'b0;
            byte_cnt_d  = (bus.len == 5'd0) ? BW'(32) : BW'(bus.len);
            guard_cnt_d = '0;
          end
        end
        SETUP: begin
          if (guard_cnt_q == CW'(SS_GUARD - 1)) begin
            guard_cnt_d = '0;
            state_d     = LOAD;
          end else begin
            guard_cnt_d = guard_cnt_q + CW'(1);
          end
        end
        LOAD: begin
          tx_d        = bus.DATA_in;
          mosi_d      = bus.DATA_in[0];
          byte_load_d = 1'b1;
          edge_cnt_d  = '0;
          div_cnt_d   = '0;
          state_d     = TRANS;
        end
        TRANS: begin
          if (div_cnt_q == CW'(CLK_DIV - 1)) begin
            div_cnt_d  = '0;
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + EW'(1);
            if (!sclk_q) begin
              // Rising edge: bit 0 is already on MOSI for the first one
              if (edge_cnt_q != '0) begin
                tx_d   = tx_q >> 1;
                mosi_d = tx_q[1];
              end
            end else begin
              // Falling edge: capture MISO, LSB ends up in bit 0
              rx_d = {bus.MISO, rx_q[DW-1:1]};
              if (edge_cnt_q == EW'(15)) begin
                state_d = NEXT;
              end
            end
          end else begin
            div_cnt_d = div_cnt_q + CW'(1);
          end
        end
        NEXT: begin
          data_out_d  = rx_q;
          eob_d       = 1'b1;
          byte_cnt_d  = byte_cnt_q - BW'(1);
          guard_cnt_d = '0;
          state_d     = (byte_cnt_q == BW'(1)) ? HOLD : LOAD;
        end
        HOLD: begin
          if (guard_cnt_q == CW'(SS_GUARD - 1)) begin
            guard_cnt_d = '0;
            ss_d        = 1'b1;
            mosi_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            guard_cnt_d = guard_cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      ss_q        <= 1'b1;
      mosi_q      <= 1'b0;
      data_out_q  <= '0;
      eob_q       <= 1'b0;
      byte_load_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_cnt_q  <= '0;
      guard_cnt_q <= '0;
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      data_out_q  <= data_out_d;
      eob_q       <= eob_d;
      byte_load_q <= byte_load_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      byte_cnt_q  <= byte_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
    end
  end

  assign bus.SCLK      = sclk_q;
  assign bus.SS        = ss_q;
  assign bus.MOSI      = mosi_q;
  assign bus.DATA_out  = data_out_q;
  assign bus.EoB       = eob_q;
  assign bus.byte_load = byte_load_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_master_comm.sv
// Directed bench for spi_master_comm with a behavioural CPHA=1 slave.
module tb_spi_master_comm;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned SS_GUARD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_comm_if bus_if();

  spi_master_comm #(.CLK_DIV(CLK_DIV), .SS_GUARD(SS_GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [4:0]      len;
    int              nbytes;
    logic [3:0][7:0] tx;       // byte 0 is the rightmost
    logic [3:0][7:0] slv;
    int              exp_edges;
    int              exp_ss_low;
    logic [7:0]      exp_last;
  } vec_t;

  vec_t vecs[4];

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state
  int         ss_low, edges, rises, eob_cnt, bl_cnt, done_cnt, ab_cnt;
  int         rise_bit, mbyte, nbytes_cur;
  logic       sclk_prev;
  logic [7:0] cur_mosi;
  logic [7:0] tx_arr   [32];
  logic [7:0] slv_arr  [32];
  logic [7:0] mosi_log [32];
  logic [7:0] rx_log   [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observe outputs once per cycle and play the slave side
  task automatic sample();
    if (bus_if.SS == 1'b0) ss_low++;
    if (bus_if.SCLK && !sclk_prev) begin
      rises++;
      edges++;
      if (mbyte < 32) begin
        cur_mosi[3'(rise_bit)] = bus_if.MOSI;
        bus_if.MISO = slv_arr[5'(mbyte)][3'(rise_bit)];
      end
      rise_bit++;
      if (rise_bit == 8) begin
        if (mbyte < 32) mosi_log[5'(mbyte)] = cur_mosi;
        mbyte++;
        rise_bit = 0;
      end
    end else if (!bus_if.SCLK && sclk_prev) begin
      edges++;
    end
    sclk_prev = bus_if.SCLK;
    if (bus_if.EoB) begin
      if (eob_cnt < 32) rx_log[5'(eob_cnt)] = bus_if.DATA_out;
      eob_cnt++;
    end
    if (bus_if.byte_load) begin
      bl_cnt++;
      if (bl_cnt < nbytes_cur) bus_if.DATA_in = tx_arr[5'(bl_cnt)];
    end
    if (bus_if.done) done_cnt++;
    if (bus_if.aborted) ab_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_mon();
    ss_low = 0; edges = 0; rises = 0; eob_cnt = 0; bl_cnt = 0;
    done_cnt = 0; ab_cnt = 0; rise_bit = 0; mbyte = 0;
    cur_mosi = 8'h00;
    sclk_prev = bus_if.SCLK;
    bus_if.MISO = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    nbytes_cur = v.nbytes;
    for (int i = 0; i < 32; i++) begin
      if (v.nbytes == 32) begin
        tx_arr[i]  = 8'(8'hC0 + i);
        slv_arr[i] = 8'(i) ^ 8'h5A;
      end else if (i < 4) begin
        tx_arr[i]  = v.tx[2'(i)];
        slv_arr[i] = v.slv[2'(i)];
      end else begin
        tx_arr[i]  = 8'h00;
        slv_arr[i] = 8'h00;
      end
    end
  endtask

  // One complete frame; hold keeps start high until done is seen
  task automatic run_frame(input vec_t v, input bit hold, input string tag);
    int t;
    load_vec(v);
    clear_mon();
    bus_if.DATA_in = tx_arr[0];
    bus_if.len     = v.len;
    bus_if.start   = 1'b1;
    step();
    check({tag, " start_resp busy/SS"}, 32'({bus_if.busy, bus_if.SS}), 32'(2'b10));
    if (!hold) bus_if.start = 1'b0;
    t = 0;
    while (done_cnt == 0 && ab_cnt == 0 && t < 3000) begin
      step();
      t++;
    end
    bus_if.start = 1'b0;
    check({tag, " finished"}, 32'(t < 3000), 32'(1));
    repeat (4) step();
    check({tag, " done_cnt"},  32'(done_cnt), 32'(1));
    check({tag, " abort_cnt"}, 32'(ab_cnt),   32'(0));
    check({tag, " eob_cnt"},   32'(eob_cnt),  32'(v.nbytes));
    check({tag, " bload_cnt"}, 32'(bl_cnt),   32'(v.nbytes));
    check({tag, " sclk_edges"}, 32'(edges),   32'(v.exp_edges));
    check({tag, " ss_low"},    32'(ss_low),   32'(v.exp_ss_low));
    check({tag, " data_out"},  32'(bus_if.DATA_out), 32'(v.exp_last));
    check({tag, " idle busy/SS/SCLK/MOSI"},
          32'({bus_if.busy, bus_if.SS, bus_if.SCLK, bus_if.MOSI}), 32'(4'b0100));
    for (int i = 0; i < v.nbytes; i++) begin
      check($sformatf("%s mosi_byte%0d", tag, i), 32'(mosi_log[i]), 32'(tx_arr[i]));
      check($sformatf("%s rx_byte%0d", tag, i),   32'(rx_log[i]),   32'(slv_arr[i]));
    end
  endtask

  initial begin
    int t;

    // len=1: A5 out, 3C back; SS low 2+1+32+1+2
    vecs[0].len = 5'd1; vecs[0].nbytes = 1;
    vecs[0].tx  = {8'h00, 8'h00, 8'h00, 8'hA5};
    vecs[0].slv = {8'h00, 8'h00, 8'h00, 8'h3C};
    vecs[0].exp_edges = 16; vecs[0].exp_ss_low = 38; vecs[0].exp_last = 8'h3C;
    // len=3: 2 + 3*34 + 2
    vecs[1].len = 5'd3; vecs[1].nbytes = 3;
    vecs[1].tx  = {8'h00, 8'hFF, 8'h80, 8'h01};
    vecs[1].slv = {8'h00, 8'h7E, 8'hC3, 8'h5A};
    vecs[1].exp_edges = 48; vecs[1].exp_ss_low = 106; vecs[1].exp_last = 8'h7E;
    // len=2: all-zero / all-one patterns
    vecs[2].len = 5'd2; vecs[2].nbytes = 2;
    vecs[2].tx  = {8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2].slv = {8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[2].exp_edges = 32; vecs[2].exp_ss_low = 72; vecs[2].exp_last = 8'h00;
    // len=0 means 32 bytes; last slave byte is 31^5A = 45
    vecs[3].len = 5'd0; vecs[3].nbytes = 32;
    vecs[3].tx  = '0;
    vecs[3].slv = '0;
    vecs[3].exp_edges = 512; vecs[3].exp_ss_low = 1092; vecs[3].exp_last = 8'h45;

    bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.len = 5'd0;
    bus_if.DATA_in = 8'h00; bus_if.MISO = 1'b0;
    nbytes_cur = 0;
    rst = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    check("reset outputs",
          32'({bus_if.SS, bus_if.SCLK, bus_if.MOSI, bus_if.DATA_out, bus_if.EoB,
               bus_if.byte_load, bus_if.done, bus_if.aborted, bus_if.busy}),
          32'({1'b1, 1'b0, 1'b0, 8'h00, 5'b00000}));
    rst = 1'b0;
    repeat (2) step();

    for (int k = 0; k < 4; k++) run_frame(vecs[k], 1'b0, $sformatf("vec%0d", k));

    // Abort after the 3rd SCLK rise of byte 1
    load_vec(vecs[2]);
    slv_arr[0] = 8'h3C;
    clear_mon();
    bus_if.DATA_in = 8'hA5; bus_if.len = 5'd2; bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    t = 0;
    while (rises < 3 && t < 500) begin
      step();
      t++;
    end
    check("abort reached rise3", 32'(t < 500), 32'(1));
    bus_if.abort = 1'b1;
    step();
    check("abort SS/SCLK/aborted/busy/MOSI",
          32'({bus_if.SS, bus_if.SCLK, bus_if.aborted, bus_if.busy, bus_if.MOSI}),
          32'(5'b10100));
    bus_if.abort = 1'b0;
    repeat (6) step();
    check("abort eob_cnt",   32'(eob_cnt),  32'(0));
    check("abort done_cnt",  32'(done_cnt), 32'(0));
    check("abort ab_cnt",    32'(ab_cnt),   32'(1));
    check("abort bload_cnt", 32'(bl_cnt),   32'(1));
    check("abort rises",     32'(rises),    32'(3));
    check("abort data_out",  32'(bus_if.DATA_out), 32'(8'h45));

    // start and abort together in IDLE
    clear_mon();
    bus_if.len = 5'd1; bus_if.start = 1'b1; bus_if.abort = 1'b1;
    step();
    check("idle start+abort busy/SS/aborted",
          32'({bus_if.busy, bus_if.SS, bus_if.aborted}), 32'(3'b010));
    bus_if.start = 1'b0; bus_if.abort = 1'b0;
    repeat (4) step();
    check("idle start+abort ab_cnt", 32'(ab_cnt), 32'(0));
    check("idle start+abort ss_low", 32'(ss_low), 32'(0));

    // start held high through a whole frame
    run_frame(vecs[0], 1'b1, "hold_start");

    // Asynchronous reset in the middle of TRANS
    load_vec(vecs[1]);
    clear_mon();
    bus_if.DATA_in = tx_arr[0]; bus_if.len = 5'd3; bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    t = 0;
    while (rises < 2 && t < 500) begin
      step();
      t++;
    end
    check("rst reached trans", 32'(t < 500), 32'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst SS/SCLK/busy/DATA_out",
          32'({bus_if.SS, bus_if.SCLK, bus_if.busy, bus_if.DATA_out}),
          32'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (3) step();
    check("after rst done/aborted", 32'({done_cnt[3:0], ab_cnt[3:0]}), 32'(0));
    run_frame(vecs[0], 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
